// File: rtl/boot_reset_seq.sv
// boot_reset_seq: ROM/cartridge download tracker and staggered multi-domain
// reset sequencer for the clk_sys domain, between user_io/data_io and the core.
// Optional build macro: BOOT_RESET_CART_AUTORESET_EN -- when defined, a cartridge
// load (download end) or unload also restarts the reset sequence.
module boot_reset_seq #(
  parameter int NUM_ROMS    = 1,
  parameter int IDX_W       = 8,
  parameter int CART_IDX    = 1,
  parameter int HOLD_CYCLES = 65535,
  parameter int NUM_DOM     = 2,
  parameter int STAGGER     = 16
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                req_reset,
  input  logic                dl_active,
  input  logic [IDX_W-1:0]    dl_index,
  input  logic                cart_unload,
  output logic [NUM_DOM-1:0]  rst_out,
  output logic [NUM_ROMS-1:0] rom_mask,
  output logic                rom_ready,
  output logic                cart_loaded,
  output logic [1:0]          seq_state
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int DW = $clog2(NUM_DOM + 1);

  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0]    STAG_LOAD = SW'(STAGGER - 1);
  localparam logic [DW-1:0]    DOM_LAST  = DW'(NUM_DOM - 1);
  localparam logic [IDX_W-1:0] ROM_LIM   = IDX_W'(NUM_ROMS);
  localparam logic [IDX_W-1:0] CART_I    = IDX_W'(CART_IDX);

  typedef enum logic [1:0] {
    WAIT_ROM = 2'd0,
    HOLD     = 2'd1,
    RELEASE  = 2'd2,
    RUN      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [SW-1:0]       stag_q, stag_d;
  logic [DW-1:0]       dom_q, dom_d;
  logic [NUM_DOM-1:0]  rst_q, rst_d;
  logic [NUM_ROMS-1:0] mask_q, mask_d;
  logic                ready_q, ready_d;
  logic                cart_q, cart_d;
  logic                dl_prev_q;
  logic                unload_prev_q;
  logic [IDX_W-1:0]    idx_lat_q, idx_lat_d;

  logic dl_rise, dl_fall, rom_rise, rom_fall, cart_fall, unload_rise, cause;

  // Download/cartridge edge detection, ROM mask update and reset-cause collection
  always_comb begin
    dl_rise     = dl_active & ~dl_prev_q;
    dl_fall     = dl_prev_q & ~dl_active;
    unload_rise = cart_unload & ~unload_prev_q;
    idx_lat_d   = dl_active ? dl_index : idx_lat_q;

    // The end of a download is judged on the index latched while it was active,
    // since dl_index is not meaningful once dl_active has dropped.
    rom_rise  = dl_rise && (dl_index < ROM_LIM);
    rom_fall  = dl_fall && (idx_lat_q < ROM_LIM);
    cart_fall = dl_fall && (idx_lat_q == CART_I);

    mask_d = mask_q;
    for (int unsigned i = 0; i < NUM_ROMS; i++) begin
      if (dl_fall && (idx_lat_q == IDX_W'(i))) mask_d[i] = 1'b1;
      if (dl_rise && (dl_index == IDX_W'(i)))  mask_d[i] = 1'b0;
    end
    ready_d = &mask_d;

    // Unload takes priority over a simultaneous cartridge download end
    cart_d = cart_q;
    if (unload_rise)    cart_d = 1'b0;
    else if (cart_fall) cart_d = 1'b1;

`ifdef BOOT_RESET_CART_AUTORESET_EN
    cause = req_reset | rom_rise | rom_fall | cart_fall | unload_rise;
`else
    cause = req_reset | rom_rise | rom_fall;
`endif
  end

  // Sequencer next-state: hold countdown, staggered domain release, re-entry on causes
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stag_d  = stag_q;
    dom_d   = dom_q;
    rst_d   = rst_q;

    case (state_q)
      WAIT_ROM: begin
        rst_d = '1;
        if (ready_d) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end

      HOLD: begin
        rst_d = '1;
        if (cause) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == '0) begin
          rst_d[0] = 1'b0;
          stag_d   = STAG_LOAD;
          dom_d    = DW'(1);
          state_d  = (NUM_DOM == 1) ? RUN : RELEASE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end

      RELEASE: begin
        if (cause) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          rst_d   = '1;
        end else if (stag_q == '0) begin
          for (int unsigned i = 0; i < NUM_DOM; i++) begin
            if (DW'(i) == dom_q) rst_d[i] = 1'b0;
          end
          if (dom_q == DOM_LAST) begin
            state_d = RUN;
          end else begin
            dom_d  = dom_q + DW'(1);
            stag_d = STAG_LOAD;
          end
        end else begin
          stag_d = stag_q - SW'(1);
        end
      end

      RUN: begin
        rst_d = '0;
        if (cause) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
          rst_d   = '1;
        end
      end

      default: begin
        state_d = WAIT_ROM;
        rst_d   = '1;
      end
    endcase

    // Losing any required ROM overrides everything else
    if (!ready_d) begin
      state_d = WAIT_ROM;
      rst_d   = '1;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= WAIT_ROM;
      hold_q        <= '0;
      stag_q        <= '0;
      dom_q         <= '0;
      rst_q         <= '1;
      mask_q        <= '0;
      ready_q       <= 1'b0;
      cart_q        <= 1'b0;
      dl_prev_q     <= 1'b0;
      unload_prev_q <= 1'b0;
      idx_lat_q     <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      stag_q        <= stag_d;
      dom_q         <= dom_d;
      rst_q         <= rst_d;
      mask_q        <= mask_d;
      ready_q       <= ready_d;
      cart_q        <= cart_d;
      dl_prev_q     <= dl_active;
      unload_prev_q <= cart_unload;
      idx_lat_q     <= idx_lat_d;
    end
  end

  assign rst_out     = rst_q;
  assign rom_mask    = mask_q;
  assign rom_ready   = ready_q;
  assign cart_loaded = cart_q;
  assign seq_state   = state_q;

endmodule

// File: doc/boot_reset_seq.md
Name: boot_reset_seq

Overview:
- Parametrised successor to the ad-hoc reset/rom_loaded logic in the core top levels.
- Tracks completion of NUM_ROMS required ROM downloads plus one optional cartridge slot from the data_io download stream.
- Holds a programmable reset, then releases NUM_DOM reset domains in staggered order: domain 0 (e.g. memory controller) first, CPU/video last.
- Sits between user_io/data_io and the machine core, in the clk_sys domain.

Parameters:
- NUM_ROMS, 1: required download indices 0..NUM_ROMS-1; all must complete before first release.
- IDX_W, 8: width of dl_index.
- CART_IDX, 1: download index treated as cartridge; must be >= NUM_ROMS.
- HOLD_CYCLES, 65535: cycles reset is held after the last reset cause; must be >= 1.
- NUM_DOM, 2: number of reset domain outputs; must be >= 1.
- STAGGER, 16: cycles between successive domain releases; must be >= 1.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous active-low reset (PLL-locked power-on reset).
- req_reset  in  1  level reset request (OSD reset OR button); active-high.
- dl_active  in  1  ioctl_download level from data_io.
- dl_index  in  IDX_W  ioctl_index; valid while dl_active is high.
- cart_unload  in  1  OSD cart-unload trigger; rising-edge sensitive.
- rst_out  out  NUM_DOM  active-high per-domain reset; bit 0 releases first.
- rom_mask  out  NUM_ROMS  bit i set = ROM index i loaded.
- rom_ready  out  1  AND of rom_mask.
- cart_loaded  out  1  cartridge present.
- seq_state  out  2  FSM state, for debug/LED: 0 WAIT_ROM, 1 HOLD, 2 RELEASE, 3 RUN.

Behaviour:
- Clock and reset:
  - Single clock clk_sys.
  - reset_n is synchronous and active-low. While low: rst_out = all ones, rom_mask = 0, rom_ready = 0, cart_loaded = 0, state = WAIT_ROM, hold counter = 0, stagger counter = 0, edge-detect registers = 0.
  - Outputs are registered.
- Download tracking:
  - idx_lat captures dl_index every cycle that dl_active = 1.
  - dl_prev registers dl_active. A falling edge is dl_prev = 1 and dl_active = 0.
  - The edge is evaluated against idx_lat, not the live dl_index.
- Rising edge of dl_active with dl_index < NUM_ROMS:
  - clears that rom_mask bit the same cycle, because the ROM is being overwritten;
  - is a reset cause.
- Falling edge with idx_lat < NUM_ROMS: sets that rom_mask bit; is a reset cause.
- Falling edge with idx_lat == CART_IDX: sets cart_loaded.
- Rising edge of cart_unload (registered edge detect): clears cart_loaded.
- Other indices are ignored.
- Reset causes: req_reset high, ROM download start/end, plus cart events per Optional Feature.
- FSM (transition takes effect on the next clock):
  - WAIT_ROM: rst_out = all ones. Move to HOLD when rom_ready = 1 (after the mask update), with counter = HOLD_CYCLES-1.
  - HOLD: rst_out = all ones. Any cause reloads counter to HOLD_CYCLES-1. Otherwise decrement. At 0, go to RELEASE; deassert rst_out[0] on entry and load stagger counter with STAGGER-1.
  - RELEASE: at stagger counter = 0, deassert the next domain bit and reload. When the last bit deasserts, go to RUN. With NUM_DOM = 1, go straight from HOLD to RUN.
  - RUN: rst_out = 0 while no cause is present.
  - From RELEASE or RUN: any cause reasserts all rst_out bits on the next cycle and enters HOLD with counter reloaded.
  - From any state: rom_ready falling to 0 enters WAIT_ROM.
- Release latency from last cause in HOLD:
  - rst_out[0] low exactly HOLD_CYCLES+1 cycles after the cause cycle;
  - rst_out[k] low k*STAGGER cycles later.
- Width rules:
  - hold counter width = $clog2(HOLD_CYCLES+1);
  - stagger counter width = $clog2(STAGGER+1);
  - domain index width = $clog2(NUM_DOM+1).
  - No wrap: counters never decrement below 0.
- Simultaneous events:
  - ROM falling edge plus req_reset in one cycle: mask set and hold reloaded; req_reset high keeps HOLD indefinitely.
  - cart_unload and cart download end in one cycle: unload wins, cart_loaded = 0.
- A reset_n assertion mid-sequence aborts immediately to the reset values. Loaded ROMs are forgotten and must be re-downloaded.

Optional Feature:
- Macro: BOOT_RESET_CART_AUTORESET_EN.
- Defined: a cartridge download falling edge (idx_lat == CART_IDX) and a cart_unload rising edge are additional reset causes. The machine reboots into or out of the cartridge.
- Undefined: cart events update cart_loaded only and never affect the FSM or rst_out.

Test Plan:
- Reset release without ROM. Params NUM_ROMS=2, HOLD_CYCLES=16, NUM_DOM=2, STAGGER=4.
  - Stimulus: reset_n high, no downloads for 100 cycles.
  - Required: state 0, rst_out = 2'b11, rom_mask = 0.
- Boot sequence. Same params.
  - Stimulus: download index 0 (dl_active high 10 cycles), then index 1.
  - Required: rom_mask 01 then 11. rst_out[0] falls 17 cycles after the index-1 falling edge, rst_out[1] 4 cycles later, state 3.
- Reset request during RUN.
  - Stimulus: req_reset high 3 cycles.
  - Required: rst_out = 11 the next cycle. rst_out[0] falls 17 cycles after the last high cycle.
- Cart with BOOT_RESET_CART_AUTORESET_EN defined.
  - Stimulus: in RUN, download index 1 with CART_IDX=1, NUM_ROMS=1; then pulse cart_unload.
  - Required: cart_loaded 0->1->0, each event re-enters HOLD. With the macro undefined, rst_out stays 0.
- ROM reload.
  - Stimulus: in RUN, dl_active rises with dl_index=0.
  - Required: rom_mask[0] = 0, state WAIT_ROM, rst_out = all ones until the download ends plus HOLD_CYCLES+1.
- reset_n mid-RELEASE.
  - Stimulus: reset_n low 1 cycle while rst_out = 10.
  - Required: all outputs at reset values the next cycle; rom_mask = 0.
